ahb_lite_interconnect: RTL

Parametrised single-master AHB-Lite interconnect that replaces the fixed 4-way decoder/mux bus top. It performs the following:
- decodes HADDR against a per-slave base/mask table;
- registers the data-phase select, address and write flag, gated on HREADY;
- muxes HRDATA, HREADYOUT and HRESP back to the master.

Unmapped accesses go to a built-in default slave that returns a two-cycle AHB ERROR response. The block sits between the multicycle ARM core's bus master port and the memories and peripherals (ROM, RAM, GPIO, timer, SPI).

---
 rtl/ahb_pkg.sv | 27 ++
 rtl/ahb_default_slave.sv | 47 ++++
 rtl/ahb_lite_interconnect.sv | 111 +++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer-type and response encodings, the
// default-slave state type, and the default memory map used as the
// interconnect's decode-table parameters.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // Default map: slave0 ROM, slave1 RAM, slave2 GPIO, slave3 timer/SPI.
  // Slave i occupies bits [i*32 +: 32].
  localparam logic [4*32-1:0] MAP_SLAVE_BASE =
    {32'h4000_1000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000};
  localparam logic [4*32-1:0] MAP_SLAVE_MASK =
    {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFE_0000, 32'hFFFF_0000};

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: answers every accepted NONSEQ/SEQ
// transfer with a two-cycle ERROR response; IDLE/BUSY get a zero-wait OKAY.
// Ports:
//   HCLK, HRESET  clock and synchronous active-high reset
//   HSEL          address-phase select (no mapped slave matched)
//   HREADY        bus-wide ready (transfer accepted when high)
//   HTRANS        master transfer type
//   HREADYOUT     ready to the response mux
//   HRESP         response to the response mux
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HSEL,
  input  logic       HREADY,
  input  logic [1:0] HTRANS,
  output logic       HREADYOUT,
  output logic       HRESP
);

  ds_state_e state_q, state_d;
  logic      accept;

  assign accept = HSEL & HREADY &
                  ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= DS_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (accept) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = accept ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  // Outputs depend on state only, so HREADY never loops back through here.
  assign HREADYOUT = (state_q != DS_ERR1);
  assign HRESP     = (state_q != DS_IDLE) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Single-master AHB-Lite interconnect: base/mask address decode, data-phase
// select/address/write registers, and response mux with a built-in default
// slave for unmapped addresses.
// Ports:
//   HCLK, HRESET            clock and synchronous active-high reset
//   HADDR, HTRANS, HWRITE   master address phase
//   HREADY, HRDATA, HRESP   response to master (HREADY also goes to slaves)
//   HSEL_S                  one-hot address-phase slave selects
//   HADDR_D, HWRITE_D       registered data-phase address and write flag
//   HRDATA_S, HREADYOUT_S,
//   HRESP_S                 packed per-slave responses
module ahb_lite_interconnect
  import ahb_pkg::*;
#(
  parameter int                     NSLAVES    = 4,
  parameter int                     AW         = 32,
  parameter int                     DW         = 32,
  parameter logic [NSLAVES*AW-1:0]  SLAVE_BASE = MAP_SLAVE_BASE,
  parameter logic [NSLAVES*AW-1:0]  SLAVE_MASK = MAP_SLAVE_MASK
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [AW-1:0]         HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  output logic                  HREADY,
  output logic [DW-1:0]         HRDATA,
  output logic                  HRESP,
  output logic [NSLAVES-1:0]    HSEL_S,
  output logic [AW-1:0]         HADDR_D,
  output logic                  HWRITE_D,
  input  logic [NSLAVES*DW-1:0] HRDATA_S,
  input  logic [NSLAVES-1:0]    HREADYOUT_S,
  input  logic [NSLAVES-1:0]    HRESP_S
);

  localparam int SW = $clog2(NSLAVES + 1);
  localparam logic [SW-1:0] DEF_IDX = SW'(NSLAVES);

  logic [SW-1:0] dec_idx;
  logic          def_sel;
  logic [SW-1:0] dsel_q, dsel_d;
  logic [AW-1:0] haddr_q, haddr_d;
  logic          hwrite_q, hwrite_d;
  logic          ds_ready, ds_resp;

  // Address decode. Scanning from the top index down lets the lowest
  // matching index overwrite the others, so overlaps resolve low-first.
  always_comb begin
    dec_idx = DEF_IDX;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((HADDR & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW])
        dec_idx = SW'(i);
    end
    HSEL_S = '0;
    for (int i = 0; i < NSLAVES; i++) HSEL_S[i] = (dec_idx == SW'(i));
    def_sel = (dec_idx == DEF_IDX);
  end

  // Data-phase registers advance only when the current data phase completes.
  always_comb begin
    dsel_d   = dsel_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    if (HREADY) begin
      dsel_d   = dec_idx;
      haddr_d  = HADDR;
      hwrite_d = HWRITE;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_q   <= DEF_IDX;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
    end else begin
      dsel_q   <= dsel_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
    end
  end

  assign HADDR_D  = haddr_q;
  assign HWRITE_D = hwrite_q;

  ahb_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (def_sel),
    .HREADY    (HREADY),
    .HTRANS    (HTRANS),
    .HREADYOUT (ds_ready),
    .HRESP     (ds_resp)
  );

  // Response mux; anything not matching a real slave index is the default slave.
  always_comb begin
    HRDATA = '0;
    HREADY = ds_ready;
    HRESP  = ds_resp;
    for (int i = 0; i < NSLAVES; i++) begin
      if (dsel_q == SW'(i)) begin
        HRDATA = HRDATA_S[i*DW +: DW];
        HREADY = HREADYOUT_S[i];
        HRESP  = HRESP_S[i];
      end
    end
  end

endmodule
